refresh_sched: RTL and testbench
================================

REFRESH_SCHED -- requirements
Module: refresh_sched

Interface
REQ-001 SHALL have parameter INTERVAL, default 390, meaning clk cycles per owed refresh (7.8 us at 50 MHz).
REQ-002 SHALL have parameter MAX_DEBT, default 8, meaning debt level that forces an urgent refresh.
REQ-003 SHALL have parameter M2_TIMEOUT, default 1024, meaning clk cycles without an M2 falling edge before M2 counts as dead.
REQ-004 SHALL have parameter GAP, default 4, meaning minimum clk cycles from an ack to the next request.
REQ-005 SHALL have port clk, input, 1, the single system clock.
REQ-006 SHALL have port async_nreset, input, 1, the reset: asynchronous and active-low.
REQ-007 SHALL have port m2, input, 1, the raw cartridge M2, asynchronous to clk.
REQ-008 SHALL have port refresh_req, output, 1, the auto-refresh request to the SDRAM controller.
REQ-009 SHALL have port refresh_ack, input, 1, a one-cycle pulse from the controller when the refresh command issues.
REQ-010 SHALL have port debt, output, $clog2(MAX_DEBT+1), the number of refreshes currently owed.
REQ-011 SHALL have port m2_alive, output, 1, high while M2 edges arrive within M2_TIMEOUT.
REQ-012 SHALL have port overflow, output, 1, sticky: debt was already MAX_DEBT when another tick arrived.

Function
REQ-013 SHALL pass m2 through a 2-flop synchronizer plus one history flop, and detect a falling edge (hist=1, cur=0); latency is 3 cycles from the pin.
REQ-014 SHALL run an interval counter 0..INTERVAL-1 that wraps, pulsing tick on the wrap cycle.
REQ-015 SHALL, on tick, increment debt, saturating at MAX_DEBT; a tick while debt==MAX_DEBT SHALL set overflow.
REQ-016 SHALL, on refresh_ack, decrement debt; tick and ack in the same cycle SHALL leave debt unchanged, and overflow SHALL NOT set then.
REQ-017 SHALL use a watchdog that reloads on each M2 falling edge; on reaching M2_TIMEOUT it SHALL clear m2_alive, and the next falling edge SHALL set m2_alive.
REQ-018 SHALL implement the FSM IDLE -> REQ -> GAP -> IDLE.
REQ-019 SHALL move IDLE -> REQ when debt>0 and any one of: an M2 falling edge while m2_alive; m2_alive==0; or debt==MAX_DEBT (urgent).
REQ-020 SHALL hold refresh_req high in REQ, and only in REQ; it SHALL NOT drop before ack.
REQ-021 SHALL move REQ -> GAP on refresh_ack, then wait GAP cycles and return to IDLE.
REQ-022 SHALL treat an ack outside REQ as a protocol error: ignore it and leave debt unchanged.
REQ-023 SHALL drop an M2 edge that arrives in REQ or GAP and SHALL NOT queue it.

Reset
REQ-024 SHALL, on async_nreset low, immediately force: FSM=IDLE, refresh_req=0, debt=0, overflow=0, m2_alive=0, interval counter=0, watchdog=0, synchronizer flops=1.
REQ-025 SHALL, on async deassertion, restart everything from the reset values, with no request issued for a refresh owed before reset.

Configuration
REQ-026 SHALL, with REFRESH_STATS_EN defined, add 16-bit outputs stat_total (count of acks) and stat_urgent (count of urgent-triggered requests), both wrapping and both reset to 0.
REQ-027 SHALL, without REFRESH_STATS_EN, omit those ports and counters entirely, with all other behaviour identical.

Structure
REQ-028 SHALL declare the state enum refresh_state_t {IDLE, REQ, GAP} and the default parameter constants in sdram_pkg.
REQ-029 SHALL place synchronizer, edge detect and watchdog in one sub-module, m2_monitor, which outputs fall_pulse and alive.

Verification
REQ-030 SHALL test idle M2: with m2 held at 0 and INTERVAL=390, req rises 1 cycle after tick 390; with ack 2 cycles later, debt goes 1->0 and the next req comes at cycle 780.
REQ-031 SHALL test M2 aligned: with a 1.79 MHz m2 toggling and debt=1, req asserts exactly 4 cycles after the m2 falling pin edge, not before.
REQ-032 SHALL test urgent: with m2 alive and edges suppressed by a controller never acking, debt climbs to 8; req stays high, the 9th tick sets overflow=1 and debt holds at 8.
REQ-033 SHALL test simultaneous events: tick and ack in the same cycle with debt=3 give debt=3 next cycle and overflow unchanged.
REQ-034 SHALL test reset mid-operation: async_nreset low while req=1 and debt=5 gives req=0 and debt=0 in the same cycle, without waiting for a clk edge.
REQ-035 SHALL test the GAP rule: with GAP=4 and debt=2, the ack at cycle N gives the next req no earlier than cycle N+5.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg -- shared types and default constants for the SDRAM refresh
// scheduler (refresh_sched and its m2_monitor sub-block).
//   refresh_state_t : scheduler FSM states IDLE -> REQ -> GAP -> IDLE
//   DEF_*           : default values for the refresh_sched parameters
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } refresh_state_t;

  // 390 cycles at 50 MHz is one 7.8 us refresh slot
  localparam int DEF_INTERVAL   = 390;
  localparam int DEF_MAX_DEBT   = 8;
  localparam int DEF_M2_TIMEOUT = 1024;
  localparam int DEF_GAP        = 4;

endpackage

// File: rtl/refresh_sched_m2_monitor.sv
// m2_monitor -- brings the cartridge M2 pin into the clk domain, detects
// its falling edges and tracks whether M2 is still running.
// Ports:
//   clk, async_nreset : system clock, asynchronous active-low reset
//   m2                : raw M2 pin, asynchronous to clk
//   fall_pulse        : one-cycle registered pulse, 3 clk edges after the
//                       pin falls (2 sync flops + history compare)
//   alive             : high from a falling edge until M2_TIMEOUT cycles
//                       pass without another one
module m2_monitor #(
  parameter int M2_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic m2,
  output logic fall_pulse,
  output logic alive
);

  localparam int WD_W = $clog2(M2_TIMEOUT + 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            hist_q, hist_d;
  logic            fall_q, fall_d;
  logic            alive_q, alive_d;
  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    sync1_d = m2;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    fall_d  = hist_q & ~sync2_q;
    wd_d    = wd_q;
    alive_d = alive_q;
    // The watchdog parks at M2_TIMEOUT so it cannot wrap back into range
    if (fall_d) begin
      wd_d    = '0;
      alive_d = 1'b1;
    end else if (wd_q != WD_W'(M2_TIMEOUT)) begin
      wd_d = wd_q + WD_W'(1);
      if (wd_d == WD_W'(M2_TIMEOUT)) alive_d = 1'b0;
    end
  end

  // Sync flops reset high so a pin already low at release reads as a fall
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      fall_q  <= 1'b0;
      alive_q <= 1'b0;
      wd_q    <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      fall_q  <= fall_d;
      alive_q <= alive_d;
      wd_q    <= wd_d;
    end
  end

  assign fall_pulse = fall_q;
  assign alive      = alive_q;

endmodule

// File: rtl/refresh_sched.sv
// refresh_sched -- tracks SDRAM refreshes owed (one per INTERVAL cycles) and
// requests them from the controller, preferably right after an M2 falling
// edge (CPU bus idle), otherwise immediately when M2 is dead or the debt
// reaches MAX_DEBT.
// Ports:
//   clk, async_nreset : system clock, asynchronous active-low reset
//   m2                : raw cartridge M2 pin
//   refresh_req       : held high until the controller acks
//   refresh_ack       : one-cycle pulse when the refresh command issues
//   debt              : refreshes currently owed (saturates at MAX_DEBT)
//   m2_alive          : M2 edges are arriving within M2_TIMEOUT
//   overflow          : sticky, a refresh slot was lost at full debt
//   stat_total/stat_urgent : ack and urgent-request counters, present only
//                       when the REFRESH_STATS_EN macro is defined
module refresh_sched
  import sdram_pkg::*;
#(
  parameter int INTERVAL   = DEF_INTERVAL,
  parameter int MAX_DEBT   = DEF_MAX_DEBT,
  parameter int M2_TIMEOUT = DEF_M2_TIMEOUT,
  parameter int GAP        = DEF_GAP
) (
  input  logic                           clk,
  input  logic                           async_nreset,
  input  logic                           m2,
  output logic                           refresh_req,
  input  logic                           refresh_ack,
  output logic [$clog2(MAX_DEBT+1)-1:0]  debt,
  output logic                           m2_alive,
`ifdef REFRESH_STATS_EN
  output logic [15:0]                    stat_total,
  output logic [15:0]                    stat_urgent,
`endif
  output logic                           overflow
);

  localparam int DEBT_W = $clog2(MAX_DEBT + 1);
  localparam int CNT_W  = $clog2(INTERVAL + 1);
  localparam int GAP_W  = $clog2(GAP + 1);

  logic              fall_pulse;
  logic              alive;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              ovf_q, ovf_d;
  logic              tick, ack_ok, urgent, start;
  refresh_state_t    state_q;
  logic              req_q;
  logic [GAP_W-1:0]  gap_q;

  m2_monitor #(.M2_TIMEOUT(M2_TIMEOUT)) u_m2_monitor (
    .clk          (clk),
    .async_nreset (async_nreset),
    .m2           (m2),
    .fall_pulse   (fall_pulse),
    .alive        (alive)
  );

  always_comb begin
    tick   = (cnt_q == CNT_W'(INTERVAL - 1));
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    // Acks outside REQ are protocol errors and are ignored
    ack_ok = refresh_ack && (state_q == REQ);
    urgent = (debt_q == DEBT_W'(MAX_DEBT));
    debt_d = debt_q;
    ovf_d  = ovf_q;
    // A tick and a valid ack together cancel out, so nothing is lost
    if (tick && !ack_ok) begin
      if (urgent) ovf_d = 1'b1;
      else        debt_d = debt_q + DEBT_W'(1);
    end else if (ack_ok && !tick) begin
      debt_d = debt_q - DEBT_W'(1);
    end
    // M2 edges seen outside IDLE are simply dropped
    start = (state_q == IDLE) && (debt_q != '0) &&
            ((fall_pulse && alive) || !alive || urgent);
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      cnt_q  <= '0;
      debt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Request FSM; refresh_req is registered and high exactly while in REQ
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (refresh_ack) begin
            state_q <= sdram_pkg::GAP;
            req_q   <= 1'b0;
            gap_q   <= '0;
          end
        end
        sdram_pkg::GAP: begin
          if (gap_q == GAP_W'(GAP - 1)) state_q <= IDLE;
          else                          gap_q   <= gap_q + GAP_W'(1);
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign refresh_req = req_q;
  assign debt        = debt_q;
  assign m2_alive    = alive;
  assign overflow    = ovf_q;

`ifdef REFRESH_STATS_EN
  logic [15:0] stat_total_q, stat_total_d;
  logic [15:0] stat_urgent_q, stat_urgent_d;

  always_comb begin
    stat_total_d  = stat_total_q  + (ack_ok ? 16'd1 : 16'd0);
    stat_urgent_d = stat_urgent_q + ((start && urgent) ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      stat_total_q  <= '0;
      stat_urgent_q <= '0;
    end else begin
      stat_total_q  <= stat_total_d;
      stat_urgent_q <= stat_urgent_d;
    end
  end

  assign stat_total  = stat_total_q;
  assign stat_urgent = stat_urgent_q;
`endif

endmodule

// File: tb/tb_refresh_sched.sv
// tb_refresh_sched -- directed testbench for refresh_sched (default build,
// REFRESH_STATS_EN undefined). cyc counts rising clk edges since reset
// release; "at cycle k" means sampled on the falling edge after edge k.
// M2_TIMEOUT is shortened to 100 so a pin held low is declared dead well
// before the first refresh tick at cycle 390.
module tb_refresh_sched;

  logic       clk = 1'b0;
  logic       async_nreset = 1'b1;
  logic       m2 = 1'b1;
  logic       refresh_ack = 1'b0;
  logic       refresh_req;
  logic       m2_alive;
  logic       overflow;
  logic [3:0] debt;

  int cyc;
  int checks = 0;
  int failures = 0;

  refresh_sched #(
    .INTERVAL   (390),
    .MAX_DEBT   (8),
    .M2_TIMEOUT (100),
    .GAP        (4)
  ) dut (
    .clk          (clk),
    .async_nreset (async_nreset),
    .m2           (m2),
    .refresh_req  (refresh_req),
    .refresh_ack  (refresh_ack),
    .debt         (debt),
    .m2_alive     (m2_alive),
    .overflow     (overflow)
  );

  always #10 clk = ~clk;

  always @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) cyc <= 0;
    else               cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int k);
    int guard = 0;
    while (cyc < k && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) chk("wait_cyc", cyc, k);
  endtask

  task automatic ack_at(input int k);
    wait_cyc(k - 1);
    refresh_ack = 1'b1;
    @(negedge clk);
    refresh_ack = 1'b0;
  endtask

  task automatic do_reset(input logic lvl);
    async_nreset = 1'b0;
    m2 = lvl;
    refresh_ack = 1'b0;
    repeat (2) @(negedge clk);
    async_nreset = 1'b1;
  endtask

  task automatic m2_hold(input logic lvl, input int n);
    m2 = lvl;
    repeat (n) @(negedge clk);
  endtask

  // ~1.79 MHz M2: toggles every 14 clk cycles
  task automatic run_m2_until(input int k);
    int ph = 0;
    int guard = 0;
    while (cyc < k && guard < 10000) begin
      @(negedge clk);
      guard++;
      ph++;
      if (ph == 14) begin
        m2 = ~m2;
        ph = 0;
      end
    end
    if (cyc != k) chk("run_m2_until", cyc, k);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values while async_nreset is low
    #5 async_nreset = 1'b0;
    m2 = 1'b0;
    #1;
    chk("rst_req", refresh_req, 0);
    chk("rst_debt", debt, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_alive", m2_alive, 0);
    @(negedge clk);
    async_nreset = 1'b1;

    // M2 held low: alive times out, so each tick requests immediately
    wait_cyc(389);
    chk("idle_req_389", refresh_req, 0);
    chk("idle_debt_389", debt, 0);
    wait_cyc(390);
    chk("idle_debt_390", debt, 1);
    chk("idle_req_390", refresh_req, 0);
    chk("idle_alive", m2_alive, 0);
    wait_cyc(391);
    chk("idle_req_391", refresh_req, 1);
    ack_at(393);
    chk("idle_debt_ack", debt, 0);
    chk("idle_req_ack", refresh_req, 0);
    wait_cyc(780);
    chk("idle_req_780", refresh_req, 0);
    chk("idle_debt_780", debt, 1);
    wait_cyc(781);
    chk("idle_req_781", refresh_req, 1);

    // M2 running: request waits for a falling edge, 4 edges after the pin
    do_reset(1'b1);
    do begin
      m2_hold(1'b0, 14);
      m2_hold(1'b1, 14);
    end while (cyc < 360);
    wait_cyc(395);
    chk("align_req_pre", refresh_req, 0);
    chk("align_debt", debt, 1);
    chk("align_alive", m2_alive, 1);
    m2 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("align_req_edge", refresh_req, (i == 4) ? 1 : 0);
    end

    // Tick and ack together, then the GAP spacing and a stray ack
    do_reset(1'b1);
    wait_cyc(1559);
    chk("sim_debt_pre", debt, 3);
    chk("sim_req_pre", refresh_req, 1);
    ack_at(1560);
    chk("sim_debt", debt, 3);
    chk("sim_ovf", overflow, 0);
    chk("sim_req_gap", refresh_req, 0);
    wait_cyc(1565);
    chk("sim_req_again", refresh_req, 1);
    ack_at(1570);
    chk("gap_debt", debt, 2);
    ack_at(1572);
    chk("stray_ack_debt", debt, 2);
    wait_cyc(1574);
    chk("gap_req_n4", refresh_req, 0);
    wait_cyc(1575);
    chk("gap_req_n5", refresh_req, 1);

    // Never acked with M2 alive: debt saturates and overflow sets on tick 9
    do_reset(1'b1);
    run_m2_until(3120);
    chk("urg_debt8", debt, 8);
    chk("urg_req", refresh_req, 1);
    chk("urg_ovf_pre", overflow, 0);
    chk("urg_alive", m2_alive, 1);
    run_m2_until(3509);
    chk("urg_ovf_3509", overflow, 0);
    run_m2_until(3510);
    chk("urg_ovf_set", overflow, 1);
    chk("urg_debt_hold", debt, 8);
    chk("urg_req_hold", refresh_req, 1);

    // Asynchronous reset in the middle of a pending request
    do_reset(1'b1);
    run_m2_until(1952);
    chk("mid_debt5", debt, 5);
    chk("mid_req", refresh_req, 1);
    chk("mid_alive", m2_alive, 1);
    #3 async_nreset = 1'b0;
    #1;
    chk("mid_rst_req", refresh_req, 0);
    chk("mid_rst_debt", debt, 0);
    chk("mid_rst_alive", m2_alive, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(negedge clk);
    m2 = 1'b1;
    async_nreset = 1'b1;
    wait_cyc(389);
    chk("post_rst_req", refresh_req, 0);
    chk("post_rst_debt", debt, 0);
    wait_cyc(390);
    chk("post_rst_debt_390", debt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
